// File: rtl/cmd_frame_tx.sv
// cmd_frame_tx: validates link/voice command bytes and transmits them as 4-byte UART 8N1 frames
module cmd_frame_tx #(
  parameter int BAUD_DIV = 5208,
  parameter int N_CMD = 9,
  parameter logic [7:0] CMD_BASE = 8'h30,
  parameter logic [7:0] HDR = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] link_data,
  input  logic       link_valid,
  input  logic [7:0] voice_data,
  input  logic       voice_valid,
  input  logic [1:0] src_mode,
  output logic       line_tx,
  output logic       busy,
  output logic [3:0] cur_cmd,
  output logic       cmd_err,
  output logic       ovf
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CMAX = CW'(BAUD_DIV - 1);
  localparam logic [8:0] CMD_END = 9'(CMD_BASE) + 9'(N_CMD);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0] bit_i, bit_d;
  logic [1:0] byte_i, byte_d;
  logic [31:0] frame, frame_d;
  logic [3:0] pend_idx, take_idx;
  logic [7:0] src_b, idx_b;
  logic pend_v, pend_voice, load, tx_d, bit_end;
  logic link_en, voice_en, link_in, voice_in, link_ok, voice_ok, take, err;
  assign link_en = src_mode != 2'd1;
  assign voice_en = src_mode != 2'd0;
  assign link_in = link_data >= CMD_BASE && {1'b0, link_data} < CMD_END;
  assign voice_in = voice_data >= CMD_BASE && {1'b0, voice_data} < CMD_END;
  assign link_ok = link_valid && link_en && link_in;
  assign voice_ok = voice_valid && voice_en && voice_in;
  assign err = (link_valid && link_en && !link_in) || (voice_valid && voice_en && !voice_in);
  assign take = link_ok || voice_ok;
  assign take_idx = link_ok ? link_data[3:0] - CMD_BASE[3:0] : voice_data[3:0] - CMD_BASE[3:0];
  assign load = state == IDLE && pend_v;
  assign bit_end = cnt == CMAX;
  assign src_b = pend_voice ? 8'h02 : 8'h01;
  assign idx_b = {4'h0, pend_idx};
  always_comb begin
    state_d = state;
    cnt_d = state == IDLE || bit_end ? '0 : cnt + 1'b1;
    bit_d = bit_i;
    byte_d = byte_i;
    frame_d = frame;
    case (state)
      IDLE: if (pend_v) begin
        state_d = START;
        bit_d = '0;
        byte_d = '0;
        frame_d = {HDR + src_b + idx_b, idx_b, src_b, HDR};
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        bit_d = bit_i + 1'b1;
        state_d = bit_i == 3'd7 ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        byte_d = byte_i + 1'b1;
        state_d = byte_i == 2'd3 ? IDLE : START;
      end
    endcase
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? frame_d[{byte_d, bit_d}] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_i <= '0;
      byte_i <= '0;
      frame <= '0;
      line_tx <= 1'b1;
      busy <= 1'b0;
      cur_cmd <= '0;
      cmd_err <= 1'b0;
      ovf <= 1'b0;
      pend_v <= 1'b0;
      pend_voice <= 1'b0;
      pend_idx <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      bit_i <= bit_d;
      byte_i <= byte_d;
      frame <= frame_d;
      line_tx <= tx_d;
      busy <= state_d != IDLE;
      cmd_err <= err;
      if (load) cur_cmd <= pend_idx;
      pend_v <= take || (pend_v && !load);
      if (take) begin
        pend_voice <= !link_ok;
        pend_idx <= take_idx;
      end
      if ((link_ok && voice_ok) || (take && pend_v && !load)) ovf <= 1'b1;
    end
  end
endmodule
